instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one instruction-memory read at a time, hands the
// fetched word to decode, then waits for execute to supply the next PC. A
// misaligned jump/branch target parks the unit in a halt state until reset.
module instr_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_en,
  // Instruction memory read channel
  output logic [XLEN-1:0] imem_araddr,
  output logic            imem_arvalid,
  input  logic            imem_arready,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_rvalid,
  output logic            imem_rready,
  // Decode side
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  // Execute side
  input  logic            i_pc_update,
  input  logic [1:0]      i_pc_op,
  input  logic [XLEN-1:0] i_pc_target,
  input  logic            i_branch_taken,
  // Status
  output logic            o_misaligned,
  output logic [31:0]     o_fetch_count
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StExec,
    StHalt
  } state_e;

  typedef enum logic [1:0] {
    PcIncr   = 2'b00,
    PcJump   = 2'b01,
    PcBranch = 2'b10,
    PcRsvd   = 2'b11
  } pc_op_e;

  localparam logic [XLEN-1:0] PcStep = XLEN'(4);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  // Set once decode has taken the current instruction; EXEC then waits for execute.
  logic            acked_q, acked_d;
  logic            misaligned_q, misaligned_d;
  logic [31:0]     count_q, count_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic            target_sel;
  logic            target_bad;
  logic            inst_valid;
  logic            decode_hs;

  // Next-PC selection; only a selected target can be misaligned.
  always_comb begin
    pc_plus4   = pc_q + PcStep;
    next_pc    = pc_plus4;
    target_sel = 1'b0;
    unique case (pc_op_e'(i_pc_op))
      PcIncr:   target_sel = 1'b0;
      PcJump:   target_sel = 1'b1;
      PcBranch: target_sel = i_branch_taken;
      PcRsvd:   target_sel = 1'b0;
      default:  target_sel = 1'b0;
    endcase
    if (target_sel) begin
      next_pc = i_pc_target;
    end
    target_bad = target_sel && (i_pc_target[1:0] != 2'b00);
  end

  // Handshake outputs are pure functions of state so reset clears them at once.
  always_comb begin
    imem_arvalid  = (state_q == StAddr);
    imem_araddr   = pc_q;
    imem_rready   = (state_q == StData);
    inst_valid    = (state_q == StExec) && !acked_q;
    o_inst_valid  = inst_valid;
    o_inst        = inst_q;
    o_pc          = inst_pc_q;
    o_misaligned  = misaligned_q;
    o_fetch_count = count_q;
    decode_hs     = inst_valid && i_inst_ready;
  end

  // Next-state logic for the fetch FSM and its datapath registers.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    acked_d      = acked_q;
    misaligned_d = misaligned_q;
    count_d      = count_q;

    unique case (state_q)
      StIdle: begin
        if (i_en) begin
          state_d = StAddr;
        end
      end

      StAddr: begin
        if (imem_arready) begin
          state_d = StData;
        end
      end

      StData: begin
        // Read data arriving in any other state is dropped.
        if (imem_rvalid) begin
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
          acked_d   = 1'b0;
          state_d   = StExec;
        end
      end

      StExec: begin
        if (decode_hs) begin
          count_d = count_q + 32'd1;
          acked_d = 1'b1;
        end
        // A PC update may arrive before decode accepts; valid drops on exit either way.
        if (i_pc_update) begin
          acked_d = 1'b0;
          if (target_bad) begin
            misaligned_d = 1'b1;
            state_d      = StHalt;
          end else begin
            pc_d    = next_pc;
            state_d = i_en ? StAddr : StIdle;
          end
        end
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      acked_q      <= 1'b0;
      misaligned_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      acked_q      <= acked_d;
      misaligned_q <= misaligned_d;
      count_q      <= count_d;
    end
  end

endmodule
